// File: rtl/arith_accum_if.sv
// Handshake bundle between the arithmetic_op result bus, arith_accum and its batch consumer.
// master drives operands and out_ready; slave (the accumulator) returns readiness and the batch total.
interface arith_accum_if #(
  parameter int ACC_W = 12
);
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              op;
  logic [4:0]              sum;
  logic [4:0]              diff;
  logic [7:0]              prod;
  logic [3:0]              quot;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_acc;
  logic                    out_sat;

  modport master (
    output in_valid, op, sum, diff, prod, quot, out_ready,
    input  in_ready, out_valid, out_acc, out_sat
  );

  modport slave (
    input  in_valid, op, sum, diff, prod, quot, out_ready,
    output in_ready, out_valid, out_acc, out_sat
  );
endinterface

// File: rtl/arith_accum.sv
// Saturating accumulator over COUNT selected arithmetic_op results; out_valid rises on the edge taking the last one.
// Holds the total (in_ready low) until out_ready; clr discards the batch and wins over any handshake.
module arith_accum #(
  parameter int COUNT = 4,
  parameter int ACC_W = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  arith_accum_if.slave io
);

  typedef enum logic {ACCUM, OUT} state_t;

  localparam logic [7:0]              LAST = 8'(COUNT - 1);
  localparam logic signed [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                  state;
  logic [7:0]              cnt;
  logic signed [ACC_W-1:0] acc;
  logic                    sat;

  logic signed [ACC_W-1:0] opnd;
  logic signed [ACC_W:0]   sum_w;
  logic                    ovf_pos;
  logic                    ovf_neg;
  logic signed [ACC_W-1:0] acc_nxt;

  // Only diff is signed; the other results are unsigned magnitudes.
  always_comb begin
    opnd = '0;
    case (io.op)
      2'd0: opnd = {{(ACC_W-5){1'b0}}, io.sum};
      2'd1: opnd = {{(ACC_W-5){io.diff[4]}}, io.diff};
      2'd2: opnd = {{(ACC_W-8){1'b0}}, io.prod};
      default: opnd = {{(ACC_W-4){1'b0}}, io.quot};
    endcase
  end

  // One guard bit: overflow shows as the top two bits of sum_w disagreeing.
  always_comb begin
    sum_w   = {acc[ACC_W-1], acc} + {opnd[ACC_W-1], opnd};
    ovf_pos = ~sum_w[ACC_W] & sum_w[ACC_W-1];
    ovf_neg = sum_w[ACC_W] & ~sum_w[ACC_W-1];
    acc_nxt = ovf_pos ? MAXV : (ovf_neg ? MINV : sum_w[ACC_W-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      cnt   <= '0;
      acc   <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      state <= ACCUM;
      cnt   <= '0;
      acc   <= '0;
      sat   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (io.in_valid) begin
            acc <= acc_nxt;
            sat <= sat | ovf_pos | ovf_neg;
            cnt <= cnt + 8'd1;
            if (cnt == LAST) state <= OUT;
          end
        end
        default: begin
          if (io.out_ready) begin
            state <= ACCUM;
            cnt   <= '0;
            acc   <= '0;
            sat   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign io.in_ready  = (state == ACCUM);
  assign io.out_valid = (state == OUT);
  assign io.out_acc   = acc;
  assign io.out_sat   = sat;

endmodule

// File: tb/tb_arith_accum.sv
// Random and directed checks of arith_accum (COUNT=4 and COUNT=16 instances) against an integer batch model.
module tb_arith_accum;

  logic clk;
  logic rst_n;
  logic clr_a;
  logic clr_b;

  int n_vec;
  int n_bad;

  arith_accum_if #(.ACC_W(12)) ia ();
  arith_accum_if #(.ACC_W(12)) ib ();

  arith_accum #(.COUNT(4),  .ACC_W(12)) dut_a (.clk(clk), .rst_n(rst_n), .clr(clr_a), .io(ia));
  arith_accum #(.COUNT(16), .ACC_W(12)) dut_b (.clk(clk), .rst_n(rst_n), .clr(clr_b), .io(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state per instance: running total, accepts so far, sticky flag, total pending.
  int m_acc[2];
  int m_cnt[2];
  bit m_sat[2];
  bit m_out[2];

  task automatic chk(string tag, logic signed [31:0] got, logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset(int k);
    m_acc[k] = 0;
    m_cnt[k] = 0;
    m_sat[k] = 1'b0;
    m_out[k] = 1'b0;
  endfunction

  function automatic void model_edge(int k, int lim, bit c, bit iv, logic [1:0] op,
                                     logic [4:0] s, logic [4:0] d, logic [7:0] p,
                                     logic [3:0] q, bit ordy);
    int v;
    if (c) begin
      model_reset(k);
    end else if (!m_out[k]) begin
      if (iv) begin
        case (op)
          2'd0: v = int'(s);
          2'd1: v = (int'(d) >= 16) ? int'(d) - 32 : int'(d);
          2'd2: v = int'(p);
          default: v = int'(q);
        endcase
        m_acc[k] = m_acc[k] + v;
        if (m_acc[k] > 2047) begin
          m_acc[k] = 2047;
          m_sat[k] = 1'b1;
        end else if (m_acc[k] < -2048) begin
          m_acc[k] = -2048;
          m_sat[k] = 1'b1;
        end
        m_cnt[k]++;
        if (m_cnt[k] == lim) m_out[k] = 1'b1;
      end
    end else if (ordy) begin
      model_reset(k);
    end
  endfunction

  task automatic check_outs();
    chk("a_in_ready",  ia.in_ready,  !m_out[0]);
    chk("a_out_valid", ia.out_valid, m_out[0]);
    chk("a_out_acc",   ia.out_acc,   m_acc[0]);
    chk("a_out_sat",   ia.out_sat,   m_sat[0]);
    chk("b_in_ready",  ib.in_ready,  !m_out[1]);
    chk("b_out_valid", ib.out_valid, m_out[1]);
    chk("b_out_acc",   ib.out_acc,   m_acc[1]);
    chk("b_out_sat",   ib.out_sat,   m_sat[1]);
  endtask

  // Inputs are driven after the falling edge; model follows the rising edge; outputs checked at the next falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge(0, 4,  clr_a, ia.in_valid, ia.op, ia.sum, ia.diff, ia.prod, ia.quot, ia.out_ready);
    model_edge(1, 16, clr_b, ib.in_valid, ib.op, ib.sum, ib.diff, ib.prod, ib.quot, ib.out_ready);
    @(negedge clk);
    check_outs();
  endtask

  task automatic idle();
    clr_a = 1'b0; clr_b = 1'b0;
    ia.in_valid = 1'b0; ia.op = 2'd0; ia.sum = '0; ia.diff = '0; ia.prod = '0; ia.quot = '0;
    ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.op = 2'd0; ib.sum = '0; ib.diff = '0; ib.prod = '0; ib.quot = '0;
    ib.out_ready = 1'b1;
  endtask

  task automatic put_a(logic [1:0] op, logic [7:0] val);
    ia.in_valid = 1'b1;
    ia.op   = op;
    ia.sum  = val[4:0];
    ia.diff = val[4:0];
    ia.prod = val;
    ia.quot = val[3:0];
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    model_reset(0);
    model_reset(1);
    idle();
    rst_n = 1'b0;
    #1;
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Mixed ops: 15 + 6 + 21 + 2 = 44.
    put_a(2'd0, 8'd15); tick();
    put_a(2'd1, 8'd6);  tick();
    put_a(2'd2, 8'd21); tick();
    put_a(2'd3, 8'd2);  tick();
    chk("mix_valid", ia.out_valid, 1);
    chk("mix_acc",   ia.out_acc,   44);
    chk("mix_sat",   ia.out_sat,   0);
    ia.in_valid = 1'b0; tick();
    chk("mix_ready_after", ia.in_ready, 1);

    // Negative diff: 4 * -4.
    for (int i = 0; i < 4; i++) begin
      put_a(2'd1, 8'b11100); tick();
    end
    chk("neg_acc", ia.out_acc, -16);
    ia.in_valid = 1'b0; tick();

    // Backpressure: hold OUT for 5 cycles with a bundle waiting.
    ia.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put_a(2'd0, 8'd10); tick();
    end
    put_a(2'd0, 8'd7);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_acc",   ia.out_acc,  40);
      chk("bp_ready", ia.in_ready, 0);
    end
    ia.in_valid = 1'b0; ia.out_ready = 1'b1; tick();
    chk("bp_release_ready", ia.in_ready,  1);
    chk("bp_release_valid", ia.out_valid, 0);

    // clr together with the third accept.
    put_a(2'd0, 8'd5); tick();
    tick();
    clr_a = 1'b1; tick();
    clr_a = 1'b0;
    chk("clr_acc", ia.out_acc, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("clr_no_early_out", ia.out_valid, 0);
    tick();
    chk("clr_out_valid", ia.out_valid, 1);
    chk("clr_out_acc",   ia.out_acc,   20);
    ia.in_valid = 1'b0; tick();

    // Saturation on the COUNT=16 instance: 16 * 225 clamps at 2047.
    ib.out_ready = 1'b0;
    ib.in_valid = 1'b1; ib.op = 2'd2; ib.prod = 8'd225;
    for (int i = 0; i < 16; i++) tick();
    chk("sat_acc",   ib.out_acc,   2047);
    chk("sat_flag",  ib.out_sat,   1);
    chk("sat_valid", ib.out_valid, 1);
    ib.in_valid = 1'b0; ib.out_ready = 1'b1; tick();
    ib.in_valid = 1'b1; ib.op = 2'd0; ib.sum = 5'd1; tick();
    chk("sat_next_flag", ib.out_sat, 0);
    chk("sat_next_acc",  ib.out_acc, 1);
    ib.in_valid = 1'b0;

    // Asynchronous reset mid-batch, checked before any clock edge.
    put_a(2'd0, 8'd9); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    chk("rst_in_ready",  ia.in_ready,  1);
    chk("rst_out_valid", ia.out_valid, 0);
    chk("rst_out_acc",   ia.out_acc,   0);
    chk("rst_out_sat",   ia.out_sat,   0);
    idle();
    rst_n = 1'b1;
    tick();

    // Random traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      clr_a        = ($urandom_range(0, 31) == 0);
      clr_b        = ($urandom_range(0, 63) == 0);
      ia.in_valid  = ($urandom_range(0, 9) < 7);
      ia.op        = 2'($urandom_range(0, 3));
      ia.sum       = 5'($urandom);
      ia.diff      = 5'($urandom);
      ia.prod      = 8'($urandom);
      ia.quot      = 4'($urandom);
      ia.out_ready = ($urandom_range(0, 9) < 6);
      ib.in_valid  = ($urandom_range(0, 9) < 8);
      ib.op        = 2'($urandom_range(0, 3));
      ib.sum       = 5'($urandom);
      ib.diff      = 5'($urandom);
      ib.prod      = 8'($urandom);
      ib.quot      = 4'($urandom);
      ib.out_ready = ($urandom_range(0, 9) < 5);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/arith_accum.md
# arith_accum

Sequential consumer placed directly downstream of the combinational `arithmetic_op` unit. It captures one of that unit's four results (`sum`, `diff`, `prod`, `quot`) per accepted transaction, selected by an opcode. It accumulates `COUNT` selected results into a signed saturating accumulator. It then presents the batch total on a valid/ready output port and holds it until the consumer takes it.

## Interface
- `COUNT`, default 4: results accumulated per batch; legal range 1..255.
- `ACC_W`, default 12: accumulator and output width, signed two's complement; minimum 9.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `clr`  in  1  synchronous batch clear.
- `in_valid`  in  1  the operand result bundle is valid.
- `in_ready`  out  1  the block accepts a bundle this cycle.
- `op`  in  2  result select: 0=sum, 1=diff, 2=prod, 3=quot.
- `sum`  in  5  unsigned a+b.
- `diff`  in  5  a−b, 5-bit two's complement.
- `prod`  in  8  unsigned a*b.
- `quot`  in  4  unsigned a/b.
- `out_valid`  out  1  the batch total is valid.
- `out_ready`  in  1  the consumer takes the total.
- `out_acc`  out  ACC_W  signed batch total.
- `out_sat`  out  1  saturation occurred at least once in this batch.

## Operation
- The FSM has two states: ACCUM and OUT. Reset enters ACCUM.
- `in_ready` = 1 in ACCUM and 0 in OUT. `out_valid` = 1 only in OUT.
- **Accept:** a bundle is accepted when `in_valid && in_ready`.
  - The selected operand is extended to ACC_W bits. `sum`, `prod` and `quot` are zero-extended. `diff` is sign-extended, so `5'b11100` = −4.
  - `acc_next = acc + operand`, computed at ACC_W+1 bits.
  - If the result exceeds 2^(ACC_W−1)−1, the accumulator clamps to that value and the sticky `sat` bit sets. If it falls below −2^(ACC_W−1), the accumulator clamps to that value and `sat` sets.
  - The batch counter increments on each accept.
- **Batch end:** an accept that brings the counter to `COUNT` moves the FSM to OUT in the same edge, with the final sum already registered. `out_acc` is the registered accumulator and `out_sat` is the registered sticky bit.
- **OUT:** the state holds, with `out_acc` and `out_sat` stable, until `out_valid && out_ready`. On that edge the accumulator, counter and `sat` clear to 0 and the FSM returns to ACCUM.
- **`clr`:** on the next edge, the accumulator, counter and `sat` go to 0 and the FSM goes to ACCUM. `clr` has priority over a simultaneous accept, which is discarded, and over a simultaneous output handshake. It drops `out_valid` without a transfer.
- **Asynchronous reset:** mid-batch or mid-OUT, reset immediately forces all state to reset values. No partial result is emitted.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_acc`=0, `out_sat`=0. Internally, counter=0 and state=ACCUM.
- Throughput: one bundle per cycle in ACCUM.
- Latency: `out_valid` rises on the clock edge that accepts the COUNT-th bundle.
- A batch costs a minimum of COUNT+1 cycles: COUNT accepts plus at least one OUT cycle.
- `in_ready` is 0 for every OUT cycle. A bundle presented during OUT is not accepted, and upstream must hold it.
- `in_ready` returns to 1 in the cycle after the output handshake. There is no same-cycle pass-through from `out_ready` to `in_ready`.
- Outputs are registered or decoded from state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- With COUNT=1, every accept produces an output.

## Test plan
- **Reset:** assert `rst_n`=0 mid-batch → `in_ready`=1, `out_valid`=0, `out_acc`=0 and `out_sat`=0, immediately and without a clock edge.
- **Mixed ops, COUNT=4, `out_ready`=1:**
  - Stimulus: (op0, sum=15), (op1, diff=6), (op2, prod=21), (op3, quot=2) on consecutive cycles.
  - Required: `out_valid`=1 for one cycle with `out_acc`=44 and `out_sat`=0, then `in_ready`=1.
- **Negative diff:**
  - Stimulus: four accepts of op1 with `diff`=5'b11100.
  - Required: `out_acc`=−16 (12'hFF0).
- **Saturation, COUNT=16:**
  - Stimulus: sixteen accepts of op2 with `prod`=225.
  - Required: `out_acc`=2047 and `out_sat`=1. The next batch starts with `sat`=0.
- **Backpressure:**
  - Stimulus: hold `out_ready`=0 for 5 cycles in OUT, with `in_valid`=1.
  - Required: `out_acc` stable, `in_ready`=0, no bundle accepted. When `out_ready` rises, one transfer occurs and `in_ready`=1 on the next cycle.
- **`clr` priority:**
  - Stimulus: assert `clr` together with the third accept.
  - Required: the count restarts at 0 and the accumulator is 0. The bundle is dropped. The next output occurs only after 4 further accepts.
